pc_unit: RTL and testbench



---
 rtl/pc_pkg.sv | 29 ++
 rtl/pc_unit_ras_stack.sv | 68 ++++++
 rtl/pc_unit.sv | 85 ++++++++
 tb/tb_pc_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
package pc_pkg;

  localparam int RAS_DEPTH_DEF = 4;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH_DEF);

  typedef enum logic [2:0] {
    NONE,
    JUMP,
    HOLD,
    RET,
    CALL,
    BRANCH,
    SEQ
  } act_e;

  // Sign-extend the low off_w bits of off to 64 bits; callers truncate.
  function automatic logic [63:0] sext_off(
    input logic [63:0] off,
    input int unsigned off_w
  );
    logic [63:0] r;
    r = off;
    if (off[off_w-1])
      r = off | ~((64'd1 << off_w) - 64'd1);
    return r;
  endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack with saturating count.
module ras_stack
  import pc_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            empty,
  output logic            full,
  output logic            ovf,
  output logic            unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(RAS_DEPTH);

  logic [PC_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   top;
  logic [PW:0]     cnt;
  logic [PW:0]     cnt_nxt;
  logic [PW-1:0]   top_nxt;

  assign dout = mem[top];

  always_comb begin
    cnt_nxt = cnt;
    top_nxt = top;
    if (push) begin
      top_nxt = top + 1'b1;
      if (cnt != DEPTH)
        cnt_nxt = cnt + 1'b1;
    end else if (pop && cnt != '0) begin
      top_nxt = top - 1'b1;
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      top   <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      top   <= top_nxt;
      cnt   <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == DEPTH);
      ovf   <= push && (cnt == DEPTH);
      unf   <= pop && !push && (cnt == '0);
    end
  end

  // When full, top+1 is the oldest slot, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (rst_n && push)
      mem[top_nxt] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with stall, jump, branch and call/return via RAS.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter int              STEP      = 1,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              OFF_W     = 8,
  parameter int              RAS_DEPTH = 2**RAS_PTR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  tgt_addr,
  input  logic [OFF_W-1:0] br_off,
  output logic [PC_W-1:0]  pc_out,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  act_e            act;
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] ras_top;
  logic            ovf;
  logic            unf;

  assign pc_seq  = pc_out + PC_W'(STEP);
  assign off_ext = PC_W'(sext_off(64'(br_off), OFF_W));
  assign ras_err = ovf | unf;

  always_comb begin
    act = NONE;
    priority case (1'b1)
      jump:     act = JUMP;
      stall:    act = HOLD;
      ret:      act = RET;
      call:     act = CALL;
      br_taken: act = BRANCH;
      default:  act = SEQ;
    endcase
  end

  always_comb begin
    pc_nxt = pc_out;
    case (act)
      JUMP:    pc_nxt = tgt_addr;
      RET:     pc_nxt = ras_empty ? pc_seq : ras_top;
      CALL:    pc_nxt = tgt_addr;
      BRANCH:  pc_nxt = pc_out + off_ext;
      SEQ:     pc_nxt = pc_seq;
      default: pc_nxt = pc_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      pc_out <= RESET_VEC;
    else
      pc_out <= pc_nxt;
  end

  ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (act == CALL),
    .pop   (act == RET),
    .din   (pc_seq),
    .dout  (ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .ovf   (ovf),
    .unf   (unf)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit.
module tb_pc_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic       jump;
  logic       call;
  logic       ret;
  logic       br_taken;
  logic [7:0] tgt_addr;
  logic [7:0] br_off;
  logic [7:0] pc_out;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_err;

  int n_chk  = 0;
  int n_fail = 0;

  pc_unit #(
    .PC_W      (8),
    .STEP      (1),
    .RESET_VEC (8'h10),
    .OFF_W     (8),
    .RAS_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .jump      (jump),
    .call      (call),
    .ret       (ret),
    .br_taken  (br_taken),
    .tgt_addr  (tgt_addr),
    .br_off    (br_off),
    .pc_out    (pc_out),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_err   (ras_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    stall = 0; jump = 0; call = 0;
    ret = 0; br_taken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic do_jump(input logic [7:0] t);
    jump = 1; tgt_addr = t;
    step();
  endtask

  task automatic do_call(input logic [7:0] t);
    call = 1; tgt_addr = t;
    step();
  endtask

  initial begin
    rst_n = 0; tgt_addr = '0; br_off = '0;
    idle_in();
    step();
    step();
    chk("rst_pc", pc_out, 8'h10);
    chk("rst_empty", ras_empty, 1);
    chk("rst_full", ras_full, 0);
    chk("rst_err", ras_err, 0);
    rst_n = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq_pc", pc_out, 8'(8'h10 + i));
      chk("seq_empty", ras_empty, 1);
    end

    do_jump(8'h02);
    chk("jmp_pc", pc_out, 8'h02);
    br_taken = 1; br_off = 8'hFC;
    step();
    chk("br_wrap", pc_out, 8'hFE);
    step();
    chk("seq_ff", pc_out, 8'hFF);
    step();
    chk("seq_wrap", pc_out, 8'h00);

    do_jump(8'h20);
    do_call(8'h80);
    chk("call_pc", pc_out, 8'h80);
    chk("call_empty", ras_empty, 0);
    step();
    step();
    chk("call_idle", pc_out, 8'h82);
    ret = 1;
    step();
    chk("ret_pc", pc_out, 8'h21);
    chk("ret_empty", ras_empty, 1);

    for (int i = 0; i < 5; i++) begin
      do_jump(8'(i * 16));
      do_call(8'((i + 1) * 16));
      chk("ovf_pc", pc_out, 8'((i + 1) * 16));
      chk("ovf_err", ras_err, (i == 4) ? 1 : 0);
      chk("ovf_full", ras_full, (i >= 3) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      ret = 1;
      step();
      chk("pop_pc", pc_out, 8'(8'h41 - i * 16));
      chk("pop_err", ras_err, 0);
      chk("pop_full", ras_full, 0);
    end
    chk("pop_empty", ras_empty, 1);
    ret = 1;
    step();
    chk("unf_pc", pc_out, 8'h12);
    chk("unf_err", ras_err, 1);
    step();
    chk("unf_clr", ras_err, 0);
    chk("unf_seq", pc_out, 8'h13);

    jump = 1; call = 1; br_taken = 1;
    tgt_addr = 8'h55; br_off = 8'h07;
    step();
    chk("pri_pc", pc_out, 8'h55);
    chk("pri_empty", ras_empty, 1);
    stall = 1; call = 1; tgt_addr = 8'h99;
    step();
    chk("stall_pc", pc_out, 8'h55);
    chk("stall_empty", ras_empty, 1);
    stall = 1; jump = 1; tgt_addr = 8'h66;
    step();
    chk("stall_jmp", pc_out, 8'h66);

    do_call(8'h70);
    do_call(8'h71);
    do_call(8'h72);
    chk("pre_rst_empty", ras_empty, 0);
    stall = 1;
    step();
    chk("stall_hold_ras", pc_out, 8'h72);
    ret = 1; rst_n = 0;
    step();
    chk("mid_rst_pc", pc_out, 8'h10);
    chk("mid_rst_empty", ras_empty, 1);
    chk("mid_rst_err", ras_err, 0);
    chk("mid_rst_full", ras_full, 0);
    rst_n = 1;
    ret = 1;
    step();
    chk("post_rst_unf", ras_err, 1);
    chk("post_rst_pc", pc_out, 8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
